// File: rtl/program_loader_if.sv
// Purpose: bundle of the loader's byte-stream handshake and CPU load-port signals.
// Ports (signals):
//   in_byte/in_valid/in_ready : valid/ready byte stream into the loader
//   start                     : restart pulse from RUN or ERROR
//   inst_data/address         : word and word address presented to the CPU memories
//   write_instruction/write_data : one-cycle memory write strobes
//   cpu_rst/busy/done/error   : CPU reset and loader status
// Modports: slave = loader side, master = stream source / observer side.
interface program_loader_if #(
    parameter int ADDR_W = 10
);
    logic [7:0]        in_byte;
    logic              in_valid;
    logic              in_ready;
    logic              start;
    logic [31:0]       inst_data;
    logic [ADDR_W-1:0] address;
    logic              write_instruction;
    logic              write_data;
    logic              cpu_rst;
    logic              busy;
    logic              done;
    logic              error;

    modport slave (
        input  in_byte, in_valid, start,
        output in_ready, inst_data, address, write_instruction, write_data,
               cpu_rst, busy, done, error
    );

    modport master (
        output in_byte, in_valid, start,
        input  in_ready, inst_data, address, write_instruction, write_data,
               cpu_rst, busy, done, error
    );
endinterface

// File: rtl/program_loader.sv
// Purpose: byte-stream boot loader. Parses a frame of
//   NI(16b) | NI big-endian words | ND(16b) | ND big-endian words,
// writes instruction words then data words into the CPU memories and holds
// the CPU in reset until the whole image has been written.
// Ports:
//   clk : system clock, posedge
//   rst : asynchronous active-high reset
//   bus : program_loader_if.slave (byte stream in, CPU load port and status out)
module program_loader #(
    parameter int ADDR_W = 10,
    parameter int DEPTH  = 1024
) (
    input  logic             clk,
    input  logic             rst,
    program_loader_if.slave  bus
);
    localparam int CW = ADDR_W + 1;
    localparam logic [15:0] DEPTH16 = 16'(DEPTH);

    typedef enum logic [2:0] {
        HI0 = 3'd0, HI1 = 3'd1, LI = 3'd2, HD0 = 3'd3,
        HD1 = 3'd4, LD = 3'd5, RUN = 3'd6, ERR = 3'd7
    } state_t;

    typedef struct packed {
        logic in_ready;
        logic busy;
        logic done;
        logic error;
        logic cpu_rst;
    } status_t;

    // Status outputs that belong to a state; loaded together with the state register.
    function automatic status_t status_of(input state_t s);
        status_t r;
        case (s)
            RUN:     r = '{in_ready: 1'b0, busy: 1'b0, done: 1'b1, error: 1'b0, cpu_rst: 1'b0};
            ERR:     r = '{in_ready: 1'b0, busy: 1'b0, done: 1'b0, error: 1'b1, cpu_rst: 1'b1};
            default: r = '{in_ready: 1'b1, busy: 1'b1, done: 1'b0, error: 1'b0, cpu_rst: 1'b1};
        endcase
        return r;
    endfunction

    state_t            state_r;
    status_t           status_r;
    logic [7:0]        count_hi_r;
    logic [CW-1:0]     count_r;
    logic [CW-1:0]     word_idx_r;
    logic [1:0]        byte_cnt_r;
    logic [23:0]       shift_r;
    logic [31:0]       inst_data_r;
    logic [ADDR_W-1:0] address_r;
    logic              wr_inst_r;
    logic              wr_data_r;

    logic              take_s;
    logic [15:0]       count_s;
    logic [CW-1:0]     idx_inc_s;
    logic [31:0]       word_s;

    assign take_s    = bus.in_valid & status_r.in_ready;
    assign count_s   = {count_hi_r, bus.in_byte};
    assign idx_inc_s = word_idx_r + CW'(1);
    assign word_s    = {shift_r, bus.in_byte};

    // Loader FSM with all outputs registered.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r     <= HI0;
            status_r    <= status_of(HI0);
            count_hi_r  <= 8'd0;
            count_r     <= '0;
            word_idx_r  <= '0;
            byte_cnt_r  <= 2'd0;
            shift_r     <= 24'd0;
            inst_data_r <= 32'd0;
            address_r   <= '0;
            wr_inst_r   <= 1'b0;
            wr_data_r   <= 1'b0;
        end else begin
            wr_inst_r <= 1'b0;
            wr_data_r <= 1'b0;
            case (state_r)
                HI0, HD0: begin
                    if (take_s) begin
                        count_hi_r <= bus.in_byte;
                        state_r    <= (state_r == HI0) ? HI1 : HD1;
                        status_r   <= status_of(HI1);
                    end
                end
                HI1, HD1: begin
                    if (take_s) begin
                        if (count_s > DEPTH16) begin
                            state_r  <= ERR;
                            status_r <= status_of(ERR);
                        end else if (count_s == 16'd0) begin
                            // Empty section: skip its load state entirely.
                            state_r  <= (state_r == HI1) ? HD0 : RUN;
                            status_r <= status_of((state_r == HI1) ? HD0 : RUN);
                        end else begin
                            count_r    <= count_s[CW-1:0];
                            word_idx_r <= '0;
                            byte_cnt_r <= 2'd0;
                            state_r    <= (state_r == HI1) ? LI : LD;
                            status_r   <= status_of(LI);
                        end
                    end
                end
                LI, LD: begin
                    if ((state_r == LD) && (word_idx_r == count_r)) begin
                        // Final data strobe is on the outputs this cycle; release the CPU next.
                        state_r  <= RUN;
                        status_r <= status_of(RUN);
                    end else if (take_s) begin
                        if (byte_cnt_r == 2'd3) begin
                            inst_data_r <= word_s;
                            address_r   <= word_idx_r[ADDR_W-1:0];
                            wr_inst_r   <= (state_r == LI);
                            wr_data_r   <= (state_r == LD);
                            word_idx_r  <= idx_inc_s;
                            byte_cnt_r  <= 2'd0;
                            if (idx_inc_s == count_r) begin
                                if (state_r == LI) begin
                                    state_r  <= HD0;
                                    status_r <= status_of(HD0);
                                end else begin
                                    // Image complete: stop accepting while the last strobe is out.
                                    status_r.in_ready <= 1'b0;
                                end
                            end
                        end else begin
                            shift_r    <= {shift_r[15:0], bus.in_byte};
                            byte_cnt_r <= byte_cnt_r + 2'd1;
                        end
                    end
                end
                RUN, ERR: begin
                    if (bus.start) begin
                        state_r    <= HI0;
                        status_r   <= status_of(HI0);
                        count_hi_r <= 8'd0;
                        count_r    <= '0;
                        word_idx_r <= '0;
                        byte_cnt_r <= 2'd0;
                        shift_r    <= 24'd0;
                    end
                end
                default: begin
                    state_r  <= ERR;
                    status_r <= status_of(ERR);
                end
            endcase
        end
    end

    assign bus.in_ready          = status_r.in_ready;
    assign bus.busy              = status_r.busy;
    assign bus.done              = status_r.done;
    assign bus.error             = status_r.error;
    assign bus.cpu_rst           = status_r.cpu_rst;
    assign bus.inst_data         = inst_data_r;
    assign bus.address           = address_r;
    assign bus.write_instruction = wr_inst_r;
    assign bus.write_data        = wr_data_r;
endmodule
